output_terminal_gen: RTL

Parametrised successor of the NCO output terminal. It deserialises narrow X and Y sample slices (LSB slice first) into DATA_W-bit words and applies optional two's-complement inversion and an offset-binary bias. It presents the selected channel on a registered output with a one-cycle valid pulse. It adds reset, a busy indication and sticky overrun detection, and replaces the one-hot load shift chain with a counter-driven FSM.

---
 rtl/output_terminal_pkg.sv | 30 +++
 rtl/output_terminal_gen_slice_deserializer.sv | 37 +++
 rtl/output_terminal_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/output_terminal_pkg.sv
// Shared types and arithmetic helpers for the output terminal generator.
package output_terminal_pkg;

    // Widest word the helper functions handle; callers truncate to DATA_W.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2
    } state_e;

    // Offset-binary bias: 2^(data_w-1) when sel_sign is set, else zero.
    function automatic logic [MAX_W-1:0] bias_of(input logic sel_sign, input int unsigned data_w);
        logic [MAX_W-1:0] b;
        b = '0;
        if (sel_sign) begin
            b[data_w-1] = 1'b1;
        end
        return b;
    endfunction

    // Two's-complement negation when is is set. Evaluated at MAX_W width;
    // the low DATA_W bits equal the DATA_W-wide negation, so 0 -> 0 and
    // 2^(DATA_W-1) -> itself after truncation.
    function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] value, input logic is);
        return is ? ((~value) + MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/output_terminal_gen_slice_deserializer.sv
// One assembly register: writes SLICE_W-bit slice number idx_i into its
// position of the word when we_i is high. Slice 0 is the LSB slice.
module slice_deserializer
    import output_terminal_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned SLICE_W = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        we_i,
    input  logic [((DATA_W/SLICE_W) > 1 ? $clog2(DATA_W/SLICE_W) : 1)-1:0] idx_i,
    input  logic [SLICE_W-1:0]                          slice_i,
    output logic [DATA_W-1:0]                           word_o
);

    localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    logic [DATA_W-1:0] word_q;

    // Write the addressed slice; untouched slices keep their value.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            for (int k = 0; k < NUM_SLICES; k++) begin
                if (we_i && (idx_i == IDX_W'(k))) begin
                    word_q[k*SLICE_W +: SLICE_W] <= slice_i;
                end
            end
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/output_terminal_gen.sv
// Output terminal generator: deserialises X/Y slice streams into DATA_W
// words, optionally negates and biases them, and presents the selected
// channel on a registered output with a one-cycle valid pulse.
//
// Handshake: rdy is a start-of-word strobe sampled on each rising edge.
// In IDLE or CALC it starts a new word; in LOAD it is ignored and sets the
// sticky overrun flag. vld is high for exactly the one cycle following the
// CALC edge, during which (and afterwards, until the next CALC) dout holds
// the new result. There is no back-pressure.
module output_terminal_gen
    import output_terminal_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned SLICE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_xy,
    input  logic               sel_sign,
    input  logic [SLICE_W-1:0] xin,
    input  logic [SLICE_W-1:0] yin,
    input  logic               is_in,
    input  logic               rdy,
    output logic               vld,
    output logic               busy,
    output logic               overrun,
    output logic [DATA_W-1:0]  dout
);

    localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    if ((DATA_W % SLICE_W) != 0 || SLICE_W == 0) begin : g_bad_width
        $error("output_terminal_gen: DATA_W must be a non-zero multiple of SLICE_W");
    end
    if (DATA_W > MAX_W) begin : g_too_wide
        $error("output_terminal_gen: DATA_W exceeds helper width");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_en;
    logic               last_slice;
    logic               calc_en;
    logic               ovr_set;

    logic [DATA_W-1:0]  x_asm, y_asm;
    logic               is_q;
    logic [DATA_W-1:0]  x_res_q, x_res_d;
    logic [DATA_W-1:0]  y_res_q, y_res_d;
    logic               vld_q;
    logic               overrun_q;

    logic [MAX_W-1:0]   bias_wide;
    logic [MAX_W-1:0]   x_wide, y_wide;

    // State register and slice counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; CALC may chain directly into LOAD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rdy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CALC: begin
                cnt_d   = '0;
                state_d = rdy ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State-decoded control strobes.
    always_comb begin
        load_en    = (state_q == ST_LOAD);
        last_slice = (state_q == ST_LOAD) && (cnt_q == LAST_CNT);
        calc_en    = (state_q == ST_CALC);
        ovr_set    = (state_q == ST_LOAD) && rdy;
        busy       = (state_q == ST_LOAD) || (state_q == ST_CALC);
    end

    slice_deserializer #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W)
    ) u_deser_x (
        .clk     (clk),
        .rst     (rst),
        .we_i    (load_en),
        .idx_i   (cnt_q),
        .slice_i (xin),
        .word_o  (x_asm)
    );

    slice_deserializer #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W)
    ) u_deser_y (
        .clk     (clk),
        .rst     (rst),
        .we_i    (load_en),
        .idx_i   (cnt_q),
        .slice_i (yin),
        .word_o  (y_asm)
    );

    // Result arithmetic, modulo 2^DATA_W; carries past DATA_W are dropped.
    always_comb begin
        bias_wide = bias_of(sel_sign, DATA_W);
        x_wide    = cond_negate(MAX_W'(x_asm), is_q) + bias_wide;
        y_wide    = cond_negate(MAX_W'(y_asm), is_q) + bias_wide;
        x_res_d   = x_wide[DATA_W-1:0];
        y_res_d   = y_wide[DATA_W-1:0];
    end

    // Result registers, is_in capture, valid pulse and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_q      <= 1'b0;
            x_res_q   <= '0;
            y_res_q   <= '0;
            vld_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            vld_q <= calc_en;
            if (last_slice) begin
                is_q <= is_in;
            end
            if (calc_en) begin
                x_res_q <= x_res_d;
                y_res_q <= y_res_d;
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign vld     = vld_q;
    assign overrun = overrun_q;
    assign dout    = sel_xy ? x_res_q : y_res_q;

endmodule
